// File: rtl/walk_scheduler.sv
// rtl/walk_scheduler.sv - round-robin requester scheduler and Wishbone master for the LED walker
// Grants one requester, writes its index to the walker, polls status until idle, then pulses done.
module walk_scheduler #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic [NREQ-1:0] i_req,
  output logic [NREQ-1:0] o_grant,
  output logic [NREQ-1:0] o_done,
  output logic            o_err,
  output logic            o_busy,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic            o_wb_addr,
  output logic [31:0]     o_wb_data,
  input  logic            i_wb_stall,
  input  logic            i_wb_ack,
  input  logic [31:0]     i_wb_data
);
  localparam int LGNREQ = $clog2(NREQ);

  typedef enum logic [2:0] {IDLE, WSTB, WACK, RSTB, RACK, DONE} state_t;

  state_t              state_q, state_d;
  logic [LGNREQ-1:0]   rr_q, rr_d;
  logic [LGNREQ-1:0]   idx_q, idx_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic [NREQ-1:0]     done_q, done_d;
  logic                err_q, err_d;
  logic                cyc_q, cyc_d;
  logic                stb_q, stb_d;
  logic                we_q, we_d;
  logic [7:0]          timer_q, timer_d;

  logic                pick_valid;
  logic [LGNREQ-1:0]   pick_idx;
  logic [LGNREQ-1:0]   cand;
  logic                ack_taken;
  logic                bus_state;
  logic                poll_idle;
  logic                unused_rdata;

  assign poll_idle    = (i_wb_data[3:0] == 4'd0);
  assign unused_rdata = ^i_wb_data[31:4];
  assign bus_state    = (state_q == WSTB) || (state_q == WACK) ||
                        (state_q == RSTB) || (state_q == RACK);

  // Walk downward so the candidate closest after the pointer wins; the pointer itself is last.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = rr_q;
    cand       = rr_q;
    for (int k = NREQ; k >= 1; k--) begin
      cand = LGNREQ'((int'(rr_q) + k) % NREQ);
      if (i_req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    idx_d     = idx_q;
    grant_d   = grant_q;
    done_d    = '0;
    err_d     = 1'b0;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    we_d      = we_q;
    timer_d   = bus_state ? timer_q + 8'd1 : timer_q;
    ack_taken = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = NREQ'(1) << pick_idx;
          rr_d    = pick_idx;
          idx_d   = pick_idx;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = 1'b1;
          timer_d = 8'd0;
          state_d = WSTB;
        end
      end
      WSTB: begin
        if (!i_wb_stall) begin
          stb_d = 1'b0;
          if (i_wb_ack) begin
            ack_taken = 1'b1;
            cyc_d     = 1'b0;
            we_d      = 1'b0;
            timer_d   = 8'd0;
            state_d   = RSTB;
          end else begin
            state_d = WACK;
          end
        end
      end
      WACK: begin
        if (i_wb_ack) begin
          ack_taken = 1'b1;
          cyc_d     = 1'b0;
          we_d      = 1'b0;
          timer_d   = 8'd0;
          state_d   = RSTB;
        end
      end
      RSTB: begin
        // Entering RSTB leaves cyc low for one cycle before the read strobe goes out.
        if (!cyc_q) begin
          cyc_d = 1'b1;
          stb_d = 1'b1;
        end else if (!i_wb_stall) begin
          stb_d = 1'b0;
          if (i_wb_ack) begin
            ack_taken = 1'b1;
            cyc_d     = 1'b0;
            if (poll_idle) begin
              done_d  = grant_q;
              state_d = DONE;
            end else begin
              timer_d = 8'd0;
            end
          end else begin
            state_d = RACK;
          end
        end
      end
      RACK: begin
        if (i_wb_ack) begin
          ack_taken = 1'b1;
          cyc_d     = 1'b0;
          if (poll_idle) begin
            done_d  = grant_q;
            state_d = DONE;
          end else begin
            timer_d = 8'd0;
            state_d = RSTB;
          end
        end
      end
      DONE: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus_state && !ack_taken && (timer_q == 8'(TIMEOUT - 1))) begin
      cyc_d   = 1'b0;
      stb_d   = 1'b0;
      we_d    = 1'b0;
      err_d   = 1'b1;
      done_d  = grant_q;
      grant_d = '0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      rr_q    <= LGNREQ'(NREQ - 1);
      idx_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      timer_q <= 8'd0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      timer_q <= timer_d;
    end
  end

  assign o_grant   = grant_q;
  assign o_done    = done_q;
  assign o_err     = err_q;
  assign o_busy    = (state_q != IDLE);
  assign o_wb_cyc  = cyc_q;
  assign o_wb_stb  = stb_q;
  assign o_wb_we   = we_q;
  assign o_wb_addr = 1'b0;
  assign o_wb_data = {{(32 - LGNREQ){1'b0}}, idx_q};

endmodule
